// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter
// Shares the register file's single write port between the in-order
// writeback stage (absolute priority, never stalled) and a multi-cycle
// unit (valid/ready). Multi-cycle results are parked in an in-order
// pending buffer and drained on cycles where writeback is idle. A
// writeback to a register kills every older parked entry for that
// register, so program order (WAW) is preserved. Decode can look up
// live parked values for forwarding or stalling.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   wb_en/wb_addr/wb_wd        writeback write request (no back-pressure)
//   mc_valid/mc_ready          multi-cycle handshake
//   mc_addr/mc_wd              multi-cycle destination and data
//   q_addr1/2 -> q_hit1/2,     decode lookups over live parked entries,
//                q_wd1/2       youngest match wins, 0 when no hit
//   rf_w_en/rf_w_addr/rf_w_wd  register file write port (combinational)
//   pend_cnt                   occupied entries, live and killed
module rf_wport_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_en,
  input  logic [4:0]             wb_addr,
  input  logic [31:0]            wb_wd,
  input  logic                   mc_valid,
  output logic                   mc_ready,
  input  logic [4:0]             mc_addr,
  input  logic [31:0]            mc_wd,
  input  logic [4:0]             q_addr1,
  input  logic [4:0]             q_addr2,
  output logic                   q_hit1,
  output logic                   q_hit2,
  output logic [31:0]            q_wd1,
  output logic [31:0]            q_wd2,
  output logic                   rf_w_en,
  output logic [4:0]             rf_w_addr,
  output logic [31:0]            rf_w_wd,
  output logic [$clog2(DEPTH):0] pend_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = DEPTH[PW:0];

  logic [4:0]    addr_mem [DEPTH];
  logic [31:0]   wd_mem   [DEPTH];
  logic          live_reg [DEPTH];
  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [PW:0]   count_reg;
  logic [PW-1:0] lk_idx;

  logic wb_act;
  logic push;
  logic pop;

  assign wb_act   = wb_en && (wb_addr != 5'd0);
  assign mc_ready = (count_reg != FULL);
  assign pend_cnt = count_reg;
  // Nothing moves in a reset cycle: no accept, no pop, no write.
  assign push     = !reset && mc_valid && mc_ready;
  assign pop      = !reset && !wb_act && (count_reg != '0);

  // Write-port mux. A dead head is popped with the enable low.
  always_comb begin
    rf_w_en   = 1'b0;
    rf_w_addr = 5'd0;
    rf_w_wd   = 32'd0;
    if (!reset) begin
      if (wb_act) begin
        rf_w_en   = 1'b1;
        rf_w_addr = wb_addr;
        rf_w_wd   = wb_wd;
      end else if (count_reg != '0) begin
        rf_w_en   = live_reg[head_reg];
        rf_w_addr = addr_mem[head_reg];
        rf_w_wd   = wd_mem[head_reg];
      end
    end
  end

  // Entry payload; no reset needed since liveness gates every use.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_reg] <= mc_addr;
      wd_mem[tail_reg]   <= mc_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Per-entry live bit. A push never targets an occupied slot and a pop
  // never coincides with a kill (pop needs wb idle), so the priority
  // order only matters for the slot being written.
  // An incoming entry that collides with the same-cycle writeback is
  // older than it, so it is stored already dead. Popped entries are
  // cleared so "live" also implies "occupied" for the lookup.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_live
    always_ff @(posedge clk) begin
      if (reset) begin
        live_reg[gi] <= 1'b0;
      end else if (push && tail_reg == PW'(gi)) begin
        live_reg[gi] <= (mc_addr != 5'd0) && !(wb_act && mc_addr == wb_addr);
      end else if (pop && head_reg == PW'(gi)) begin
        live_reg[gi] <= 1'b0;
      end else if (wb_act && addr_mem[gi] == wb_addr) begin
        live_reg[gi] <= 1'b0;
      end
    end
  end

  // Lookup walks oldest to youngest so the last match (nearest the tail)
  // wins.
  always_comb begin
    q_hit1 = 1'b0;
    q_wd1  = 32'd0;
    q_hit2 = 1'b0;
    q_wd2  = 32'd0;
    lk_idx = head_reg;
    for (int k = 0; k < DEPTH; k++) begin
      lk_idx = head_reg + PW'(k);
      if (live_reg[lk_idx] && q_addr1 != 5'd0 && addr_mem[lk_idx] == q_addr1) begin
        q_hit1 = 1'b1;
        q_wd1  = wd_mem[lk_idx];
      end
      if (live_reg[lk_idx] && q_addr2 != 5'd0 && addr_mem[lk_idx] == q_addr2) begin
        q_hit2 = 1'b1;
        q_wd2  = wd_mem[lk_idx];
      end
    end
  end

  a_no_r0_write: assert property (@(posedge clk) disable iff (reset)
    rf_w_en |-> (rf_w_addr != 5'd0));

endmodule
